alfa_range_labeler: RTL and testbench

Streaming, parametrised point-cloud range labeler for the ALFA unit. It accepts packed Cartesian points from the point-cloud DMA stream, computes a distance metric per point and rewrites the point's label field using up to N_BANDS configurable range bands. It counts a frame of a configured number of points and asserts a done flag for the MonU status register. It generalises the single fixed min/max distance filter to multiple bands, signed coordinates, configurable field widths and full valid/ready backpressure.

---
 rtl/alfa_range_labeler.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alfa_range_labeler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alfa_range_labeler.sv
`default_nettype none
// ============================================================================
// Module   : alfa_range_labeler
// Brief    : Streaming point-cloud range labeler. Each packed point gets a
//            distance metric (Manhattan by default, squared Euclidean when
//            ALFA_RANGE_EUCLID_EN is defined). The label field is rewritten by
//            the lowest-index enabled band whose inclusive [min,max] range
//            contains the metric. Frame bookkeeping counts accepted and hit
//            points and raises a sticky done flag when the frame has drained.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: ALFA_RANGE_EUCLID_EN (squared Euclidean metric)
// ----------------------------------------------------------------------------
// Ports:
//   i_SYSTEM_clk / i_SYSTEM_rst  clock, synchronous active-high reset
//   i_cfg_start                  one-cycle frame start (honoured in IDLE/DONE)
//   i_cfg_num_points             points in the frame
//   i_cfg_band_en/min/max/label  per-band config, band i at [i*W +: W]
//   s_valid/s_ready/s_data       input point stream
//   m_valid/m_ready/m_data       output point stream
//   o_busy                       frame in progress (RUN or DRAIN)
//   o_done                       frame complete, held until next start
//   o_pts_in / o_pts_hit         accepted points / output points with a hit
// Point word: x [COORD_W-1:0], y [2*COORD_W-1:COORD_W],
//             z [3*COORD_W-1:2*COORD_W], label [DATA_W-1:DATA_W-LABEL_W]
// ============================================================================
module alfa_range_labeler #(
    parameter int  COORD_W = 16,
    parameter int  LABEL_W = 8,
    parameter int  DATA_W  = 64,
    parameter int  N_BANDS = 2,
    parameter int  PTS_W   = 20,
    localparam int DIST_W  = 2*COORD_W + 2
) (
    input  logic                       i_SYSTEM_clk,
    input  logic                       i_SYSTEM_rst,
    input  logic                       i_cfg_start,
    input  logic [PTS_W-1:0]           i_cfg_num_points,
    input  logic [N_BANDS-1:0]         i_cfg_band_en,
    input  logic [N_BANDS*DIST_W-1:0]  i_cfg_band_min,
    input  logic [N_BANDS*DIST_W-1:0]  i_cfg_band_max,
    input  logic [N_BANDS*LABEL_W-1:0] i_cfg_band_label,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [PTS_W-1:0]           o_pts_in,
    output logic [PTS_W-1:0]           o_pts_hit
);

    // Per-coordinate term width carried from S1 to S2.
`ifdef ALFA_RANGE_EUCLID_EN
    // Square of a magnitude up to 2^(COORD_W-1) fits in DIST_W bits, and the
    // sum of three such squares still does.
    localparam int c_TERM_W = DIST_W;
`else
    // |-2^(COORD_W-1)| needs one extra bit to be exact.
    localparam int c_TERM_W = COORD_W + 1;
`endif

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_start_ok;
    logic                w_done_set;

    logic                w_en;
    logic                w_in_fire;
    logic                w_out_fire;

    logic [c_TERM_W-1:0] w_term   [3];
    logic [c_TERM_W-1:0] r_s1_term[3];
    logic                r_s1_valid;
    logic [DATA_W-1:0]   r_s1_data;

    logic [DIST_W-1:0]   r_s2_dist;
    logic                r_s2_valid;
    logic [DATA_W-1:0]   r_s2_data;

    logic                w_hit;
    logic [LABEL_W-1:0]  w_label;
    logic [DATA_W-1:0]   w_rewrite;

    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_hit;

    logic [PTS_W-1:0]    r_pts_in;
    logic [PTS_W-1:0]    r_pts_out;
    logic [PTS_W-1:0]    r_pts_hit;
    logic [PTS_W-1:0]    w_pts_in_nxt;
    logic [PTS_W-1:0]    w_pts_out_nxt;
    logic                r_done;

    // Two's-complement magnitude, exact for the most negative value.
    function automatic logic [COORD_W:0] f_abs(input logic [COORD_W-1:0] v);
        logic [COORD_W:0] ext;
        ext = {v[COORD_W-1], v};
        return v[COORD_W-1] ? (~ext + (COORD_W+1)'(1)) : ext;
    endfunction

    // ------------------------------------------------------------------
    // Handshakes and global stall
    // ------------------------------------------------------------------
    // Every stage advances together; the pipeline only moves when the
    // output register is empty or being consumed.
    assign w_en       = !r_m_valid || m_ready;
    assign s_ready    = (r_state == c_ST_RUN) && (r_pts_in != i_cfg_num_points) && w_en;
    assign w_in_fire  = s_valid && s_ready;
    assign w_out_fire = r_m_valid && m_ready;

    assign w_pts_in_nxt  = r_pts_in  + PTS_W'(w_in_fire);
    assign w_pts_out_nxt = r_pts_out + PTS_W'(w_out_fire);

    // ------------------------------------------------------------------
    // S1: per-coordinate magnitude (or square)
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 3; k++) begin : g_coord
        logic [COORD_W:0] w_abs;
        assign w_abs = f_abs(s_data[k*COORD_W +: COORD_W]);
`ifdef ALFA_RANGE_EUCLID_EN
        assign w_term[k] = DIST_W'(w_abs) * DIST_W'(w_abs);
`else
        assign w_term[k] = w_abs;
`endif
    end

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            for (int k = 0; k < 3; k++) begin
                r_s1_term[k] <= '0;
            end
        end else if (w_en) begin
            r_s1_valid <= w_in_fire;
            r_s1_data  <= s_data;
            for (int k = 0; k < 3; k++) begin
                r_s1_term[k] <= w_term[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: metric sum
    // ------------------------------------------------------------------
    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_dist  <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= r_s1_data;
            r_s2_dist  <= DIST_W'(r_s1_term[0]) + DIST_W'(r_s1_term[1])
                        + DIST_W'(r_s1_term[2]);
        end
    end

    // ------------------------------------------------------------------
    // S3: band compare and label rewrite
    // ------------------------------------------------------------------
    // Scanning from the top band down lets the lowest hitting index win.
    always_comb begin
        w_hit   = 1'b0;
        w_label = '0;
        for (int i = N_BANDS - 1; i >= 0; i--) begin
            if (i_cfg_band_en[i] &&
                (r_s2_dist >= i_cfg_band_min[i*DIST_W +: DIST_W]) &&
                (r_s2_dist <= i_cfg_band_max[i*DIST_W +: DIST_W])) begin
                w_hit   = 1'b1;
                w_label = i_cfg_band_label[i*LABEL_W +: LABEL_W];
            end
        end
    end

    assign w_rewrite = w_hit ? {w_label, r_s2_data[DATA_W-LABEL_W-1:0]} : r_s2_data;

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_hit   <= 1'b0;
        end else if (w_en) begin
            r_m_valid <= r_s2_valid;
            r_m_data  <= w_rewrite;
            r_m_hit   <= w_hit;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    // ------------------------------------------------------------------
    // Frame control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transitions look at the post-handshake counts so DRAIN is entered on
    // the last accept and DONE on the last output handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (i_cfg_start) begin
                    w_start_ok = 1'b1;
                    if (i_cfg_num_points == '0) begin
                        w_state_nxt = c_ST_DONE;
                        w_done_set  = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                if (w_pts_in_nxt == i_cfg_num_points) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pts_out_nxt == i_cfg_num_points) begin
                    w_state_nxt = c_ST_DONE;
                    w_done_set  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame counters and done flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_pts_in  <= '0;
            r_pts_out <= '0;
            r_pts_hit <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_pts_in  <= '0;
                r_pts_out <= '0;
                r_pts_hit <= '0;
            end else begin
                r_pts_in  <= w_pts_in_nxt;
                r_pts_out <= w_pts_out_nxt;
                if (w_out_fire && r_m_hit) begin
                    r_pts_hit <= r_pts_hit + PTS_W'(1);
                end
            end
            // An empty frame clears and re-sets done in the same cycle.
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_start_ok) begin
                r_done <= 1'b0;
            end
        end
    end

    assign o_busy    = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign o_done    = r_done;
    assign o_pts_in  = r_pts_in;
    assign o_pts_hit = r_pts_hit;

endmodule
`default_nettype wire

// File: tb/tb_alfa_range_labeler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alfa_range_labeler
// Brief    : Directed self-checking bench for alfa_range_labeler with default
//            parameters. Expected words are built from hand-chosen points and
//            labels; ALFA_RANGE_EUCLID_EN selects the squared-metric vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alfa_range_labeler;

    localparam int LABEL_W = 8;
    localparam int DATA_W  = 64;
    localparam int N_BANDS = 2;
    localparam int PTS_W   = 20;
    localparam int DIST_W  = 34;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [PTS_W-1:0]           num;
    logic [N_BANDS-1:0]         band_en;
    logic [N_BANDS*DIST_W-1:0]  band_min;
    logic [N_BANDS*DIST_W-1:0]  band_max;
    logic [N_BANDS*LABEL_W-1:0] band_label;
    logic                       s_valid;
    logic                       s_ready;
    logic [DATA_W-1:0]          s_data;
    logic                       m_valid;
    logic                       m_ready;
    logic [DATA_W-1:0]          m_data;
    logic                       busy;
    logic                       done;
    logic [PTS_W-1:0]           pts_in;
    logic [PTS_W-1:0]           pts_hit;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          ready_mode = 0;   // 0: high, 1: toggle, 2: low
    int          lat;
    int          exp_hits;
    logic [63:0] tx[32];
    logic [63:0] ex[32];
    logic [63:0] rx[$];
    logic        stall_prev = 1'b0;
    logic [63:0] stall_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alfa_range_labeler dut (
        .i_SYSTEM_clk     (clk),
        .i_SYSTEM_rst     (rst),
        .i_cfg_start      (start),
        .i_cfg_num_points (num),
        .i_cfg_band_en    (band_en),
        .i_cfg_band_min   (band_min),
        .i_cfg_band_max   (band_max),
        .i_cfg_band_label (band_label),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .o_busy           (busy),
        .o_done           (done),
        .o_pts_in         (pts_in),
        .o_pts_hit        (pts_hit)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Point word: label, spare byte A5, z, y, x.
    function automatic logic [63:0] mk(input int x, input int y, input int z, input logic [7:0] lbl);
        logic [15:0] xs, ys, zs;
        xs = x[15:0];
        ys = y[15:0];
        zs = z[15:0];
        return {lbl, 8'hA5, zs, ys, xs};
    endfunction

    task automatic set_band(input int i, input logic en, input longint lo, input longint hi,
                            input logic [7:0] lbl);
        band_en[i]                      = en;
        band_min[i*DIST_W +: DIST_W]    = lo[DIST_W-1:0];
        band_max[i*DIST_W +: DIST_W]    = hi[DIST_W-1:0];
        band_label[i*LABEL_W +: LABEL_W] = lbl;
    endtask

    task automatic feed(input logic [63:0] w, output bit ok);
        bit hs;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int wt = 0; wt < 200; wt++) begin
            @(negedge clk);
            hs = s_ready;
            tick();
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) chk("in_timeout", 64'd0, 64'd1);
    endtask

    // Starts a frame, feeds tx[0..n-1], waits for done; lat is the number of
    // cycles from the last input handshake to done.
    task automatic run_frame(input int n, output int l);
        bit ok;
        int last;
        l = -1;
        rx.delete();
        num   = n[PTS_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        last  = cyc;
        for (int k = 0; k < n; k++) begin
            feed(tx[k], ok);
            if (!ok) return;
            last = cyc;
        end
        for (int w = 0; w < 300 && !done; w++) tick();
        chk("done", done, 1'b1);
        l = cyc - last;
    endtask

    task automatic check_out(input int n);
        chk("n_out", rx.size(), n);
        for (int k = 0; k < n && k < rx.size(); k++) begin
            chk($sformatf("out%0d", k), rx[k], ex[k]);
        end
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: collects handshakes and checks that a stalled word holds.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready) rx.push_back(m_data);
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; num = '0; s_valid = 1'b0; s_data = '0;
        band_en = '0; band_min = '0; band_max = '0; band_label = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pts_in", pts_in, 64'd0);
        chk("rst_pts_hit", pts_hit, 64'd0);
        rst = 1'b0;
        tick();

        // Empty frame: done on the next cycle, never ready
        num = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("n0_done", done, 1'b1);
        chk("n0_busy", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("n0_s_ready", s_ready, 1'b0);
            tick();
        end

`ifdef ALFA_RANGE_EUCLID_EN
        // 3^2+4^2+12^2 = 169
        set_band(0, 1'b1, 169, 169, 8'h11);
        set_band(1, 1'b0, 0, 0, 8'h00);
        tx[0] = mk(3, 4, 12, 8'h00);
        ex[0] = mk(3, 4, 12, 8'h11);
        run_frame(1, lat);
        check_out(1);
        chk("eu_hit_cnt", pts_hit, 64'd1);
        set_band(0, 1'b1, 168, 168, 8'h11);
        ex[0] = mk(3, 4, 12, 8'h00);
        run_frame(1, lat);
        check_out(1);
        chk("eu_miss_cnt", pts_hit, 64'd0);
`else
        // Single band [500,1000] -> label 1
        set_band(0, 1'b1, 500, 1000, 8'h01);
        set_band(1, 1'b0, 0, 5000, 8'h02);
        tx[0] = mk(300, 200, 0, 8'h00);   ex[0] = mk(300, 200, 0, 8'h01);
        tx[1] = mk(499, 0, 0, 8'h00);     ex[1] = mk(499, 0, 0, 8'h00);
        tx[2] = mk(0, 0, -1000, 8'h00);   ex[2] = mk(0, 0, -1000, 8'h01);
        tx[3] = mk(600, 600, 0, 8'h00);   ex[3] = mk(600, 600, 0, 8'h00);
        run_frame(4, lat);
        check_out(4);
        chk("t1_done_lat", lat, 64'd3);
        chk("t1_pts_in", pts_in, 64'd4);
        chk("t1_pts_hit", pts_hit, 64'd2);
        chk("t1_busy", busy, 1'b0);

        // Priority: band0 [0,100] label 5 beats band1 [50,200] label 7
        set_band(0, 1'b1, 0, 100, 8'h05);
        set_band(1, 1'b1, 50, 200, 8'h07);
        tx[0] = mk(75, 0, 0, 8'h3C);      ex[0] = mk(75, 0, 0, 8'h05);
        tx[1] = mk(0, -150, 0, 8'h3C);    ex[1] = mk(0, -150, 0, 8'h07);
        tx[2] = mk(100, 100, 50, 8'h3C);  ex[2] = mk(100, 100, 50, 8'h3C);
        tx[3] = mk(-30, -30, 0, 8'h3C);   ex[3] = mk(-30, -30, 0, 8'h05);
        run_frame(4, lat);
        check_out(4);
        chk("t2_pts_hit", pts_hit, 64'd3);

        // Most negative coordinate: |x| = 32768 exactly
        set_band(0, 1'b1, 32768, 32768, 8'h09);
        set_band(1, 1'b0, 0, 0, 8'h00);
        tx[0] = mk(-32768, 0, 0, 8'h00);  ex[0] = mk(-32768, 0, 0, 8'h09);
        tx[1] = mk(32767, 0, 0, 8'h00);   ex[1] = mk(32767, 0, 0, 8'h00);
        run_frame(2, lat);
        check_out(2);
        chk("t4_pts_hit", pts_hit, 64'd1);
`endif

        // Backpressure: m_ready toggles, 16 points in order
        set_band(0, 1'b1, 0, 100, 8'h05);
        set_band(1, 1'b1, 50, 200, 8'h07);
        exp_hits = 0;
        for (int i = 0; i < 16; i++) begin
            longint d;
            logic [7:0] lb;
`ifdef ALFA_RANGE_EUCLID_EN
            d = longint'(i * 20) * longint'(i * 20);
`else
            d = longint'(i * 20);
`endif
            lb = i[7:0];
            tx[i] = mk(i * 20, 0, 0, lb);
            if (d <= 100)      begin ex[i] = mk(i * 20, 0, 0, 8'h05); exp_hits++; end
            else if (d <= 200) begin ex[i] = mk(i * 20, 0, 0, 8'h07); exp_hits++; end
            else                     ex[i] = tx[i];
        end
        ready_mode = 1;
        run_frame(16, lat);
        check_out(16);
        chk("bp_pts_in", pts_in, 64'd16);
        chk("bp_pts_hit", pts_hit, exp_hits);
        ready_mode = 0;
        tick();

        // Reset with three points stuck in the pipeline
        ready_mode = 2;
        tick();
        num = 20'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) feed(mk(k, 1, 2, 8'h00), ok);
        chk("mid_pts_in", pts_in, 64'd3);
        chk("mid_m_valid", m_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("mr_m_valid", m_valid, 1'b0);
        chk("mr_pts_in", pts_in, 64'd0);
        chk("mr_pts_hit", pts_hit, 64'd0);
        chk("mr_busy", busy, 1'b0);
        rst = 1'b0;
        ready_mode = 0;
        tick();
        set_band(0, 1'b1, 0, 10, 8'h0A);
        set_band(1, 1'b0, 0, 0, 8'h00);
        tx[0] = mk(1, 2, 3, 8'h00);       ex[0] = mk(1, 2, 3, 8'h0A);
        tx[1] = mk(400, 0, 0, 8'h00);     ex[1] = mk(400, 0, 0, 8'h00);
        run_frame(2, lat);
        check_out(2);
        chk("ar_pts_in", pts_in, 64'd2);
        chk("ar_pts_hit", pts_hit, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
